// File: rtl/controle_varredura_pkg.sv
// Shared types and constants for the servo sweep / ultrasonic measurement controller.
package controle_varredura_pkg;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ASSENTA  = 4'd1,
    MEDE     = 4'd2,
    AGUARDA  = 4'd3,
    REGISTRA = 4'd4,
    PROXIMA  = 4'd5
  } estado_t;

  localparam logic [11:0] DIST_TIMEOUT = 12'hFFF;

endpackage

// File: rtl/gerador_pwm_posicao.sv
// Free-running servo PWM; pulse width follows the position index, reloaded only at
// the period boundary so a pulse is never truncated. wrap_o marks the last period cycle.
module gerador_pwm_posicao #(
  parameter int unsigned CONF_PERIODO = 1000000,
  parameter int unsigned POS_W        = 3,
  parameter int unsigned LARG_MIN     = 50000,
  parameter int unsigned LARG_PASSO   = 7142
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [POS_W-1:0] posicao_i,
  output logic             pwm_o,
  output logic             wrap_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] larg_q, larg_d;
  logic        pwm_q;

  assign wrap_o = (cnt_q == 32'(CONF_PERIODO - 1));
  assign pwm_o  = pwm_q;

  always_comb begin
    cnt_d  = wrap_o ? 32'd0 : cnt_q + 32'd1;
    larg_d = larg_q;
    if (wrap_o)
      larg_d = 32'(LARG_MIN) + 32'(posicao_i) * 32'(LARG_PASSO);
  end

  // pwm is registered so it is cleanly 0 while reset is held
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= 32'd0;
      larg_q <= 32'(LARG_MIN);
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      larg_q <= larg_d;
      pwm_q  <= (cnt_q < larg_q);
    end
  end

endmodule

// File: rtl/controle_varredura.sv
// Autonomous radar sweep: settle servo, request one measurement, publish it tagged
// with its position. Define CONTROLE_VARREDURA_PINGPONG_EN for a back-and-forth sweep.
module controle_varredura
  import controle_varredura_pkg::*;
#(
  parameter int unsigned CONF_PERIODO = 1000000,
  parameter int unsigned N_POS        = 8,
  parameter int unsigned POS_W        = 3,
  parameter int unsigned LARG_MIN     = 50000,
  parameter int unsigned LARG_PASSO   = 7142,
  parameter int unsigned T_ASSENTA    = 10,
  parameter int unsigned T_TIMEOUT    = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             pronto_sensor,
  input  logic [11:0]      distancia,
  output logic             medir_sensor,
  output logic             pwm,
  output logic [POS_W-1:0] posicao,
  output logic [11:0]      medida,
  output logic             medida_valida,
  output logic             timeout,
  output logic             fim_varredura,
  output logic [3:0]       db_estado
);

  localparam logic [POS_W-1:0] ULTIMA = POS_W'(N_POS - 1);

  estado_t          estado_q, estado_d;
  logic [31:0]      assenta_q, assenta_d;
  logic [31:0]      espera_q, espera_d;
  logic [POS_W-1:0] posicao_q, posicao_d;
  logic [11:0]      medida_q, medida_d;
  logic             wrap;
  logic             fim_pos;
`ifdef CONTROLE_VARREDURA_PINGPONG_EN
  logic             desce_q, desce_d;
`endif

  gerador_pwm_posicao #(
    .CONF_PERIODO(CONF_PERIODO),
    .POS_W       (POS_W),
    .LARG_MIN    (LARG_MIN),
    .LARG_PASSO  (LARG_PASSO)
  ) u_pwm (
    .clock    (clock),
    .reset    (reset),
    .posicao_i(posicao_q),
    .pwm_o    (pwm),
    .wrap_o   (wrap)
  );

`ifdef CONTROLE_VARREDURA_PINGPONG_EN
  assign fim_pos = (posicao_q == '0) || (posicao_q == ULTIMA);
`else
  assign fim_pos = (posicao_q == ULTIMA);
`endif

  always_comb begin
    estado_d      = estado_q;
    assenta_d     = assenta_q;
    espera_d      = espera_q;
    posicao_d     = posicao_q;
    medida_d      = medida_q;
    medir_sensor  = 1'b0;
    medida_valida = 1'b0;
    timeout       = 1'b0;
    fim_varredura = 1'b0;
`ifdef CONTROLE_VARREDURA_PINGPONG_EN
    desce_d       = desce_q;
`endif
    unique case (estado_q)
      INICIAL: begin
        assenta_d = 32'd0;
        if (ligar) estado_d = ASSENTA;
      end
      ASSENTA: begin
        if (wrap) begin
          if (assenta_q == 32'(T_ASSENTA - 1)) estado_d = MEDE;
          else assenta_d = assenta_q + 32'd1;
        end
      end
      MEDE: begin
        medir_sensor = 1'b1;
        espera_d     = 32'd0;
        estado_d     = AGUARDA;
      end
      AGUARDA: begin
        // a pronto coinciding with expiry wins over the timeout
        if (pronto_sensor) begin
          medida_d = distancia;
          estado_d = REGISTRA;
        end else if (espera_q == 32'(T_TIMEOUT - 1)) begin
          medida_d = DIST_TIMEOUT;
          timeout  = 1'b1;
          estado_d = REGISTRA;
        end else begin
          espera_d = espera_q + 32'd1;
        end
      end
      REGISTRA: begin
        medida_valida = 1'b1;
        fim_varredura = fim_pos;
        estado_d      = PROXIMA;
      end
      PROXIMA: begin
`ifdef CONTROLE_VARREDURA_PINGPONG_EN
        if (!desce_q) begin
          if (posicao_q == ULTIMA) begin
            desce_d   = 1'b1;
            posicao_d = posicao_q - 1'b1;
          end else begin
            posicao_d = posicao_q + 1'b1;
          end
        end else begin
          if (posicao_q == '0) begin
            desce_d   = 1'b0;
            posicao_d = posicao_q + 1'b1;
          end else begin
            posicao_d = posicao_q - 1'b1;
          end
        end
`else
        posicao_d = (posicao_q == ULTIMA) ? '0 : posicao_q + 1'b1;
`endif
        assenta_d = 32'd0;
        estado_d  = ligar ? ASSENTA : INICIAL;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      assenta_q <= 32'd0;
      espera_q  <= 32'd0;
      posicao_q <= '0;
      medida_q  <= 12'd0;
`ifdef CONTROLE_VARREDURA_PINGPONG_EN
      desce_q   <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      assenta_q <= assenta_d;
      espera_q  <= espera_d;
      posicao_q <= posicao_d;
      medida_q  <= medida_d;
`ifdef CONTROLE_VARREDURA_PINGPONG_EN
      desce_q   <= desce_d;
`endif
    end
  end

  assign posicao   = posicao_q;
  assign medida    = medida_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_varredura.sv
// Directed bench for controle_varredura: sweep table, timeout, ligar drop, reset abort.
module tb_controle_varredura;

  localparam int PER = 100;

  logic        clock = 1'b0;
  logic        reset, ligar, pronto_sensor;
  logic [11:0] distancia;
  logic        medir_sensor, pwm, medida_valida, timeout, fim_varredura;
  logic [1:0]  posicao;
  logic [11:0] medida;
  logic [3:0]  db_estado;

  controle_varredura #(
    .CONF_PERIODO(100), .N_POS(4), .POS_W(2), .LARG_MIN(10),
    .LARG_PASSO(5), .T_ASSENTA(2), .T_TIMEOUT(300)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .pronto_sensor(pronto_sensor),
    .distancia(distancia), .medir_sensor(medir_sensor), .pwm(pwm),
    .posicao(posicao), .medida(medida), .medida_valida(medida_valida),
    .timeout(timeout), .fim_varredura(fim_varredura), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct { int pos; int med; int fim; int nmed; int cyc; } ev_t;
  typedef struct { int pos; int med; int fim; } vec_t;

  ev_t  evq[$];
  vec_t tab[7];
  int   n_ev;
  int   nerr = 0, nchk = 0;
  int   cyc = 0, medir_cnt = 0, to_cnt = 0;
  int   last_medir_cyc = 0, last_to_cyc = 0, last_pos_cyc = 0;
  int   prev_pos = 0, min_gap = 1000000;
  bit   pos_seen = 0, resp_en = 1;

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse(output int w);
    int k;
    w = -1;
    k = 0;
    while (pwm !== 1'b0 && k < 300) begin tick(); k++; end
    while (pwm !== 1'b1 && k < 600) begin tick(); k++; end
    if (k < 600) begin
      w = 0;
      while (pwm === 1'b1 && w < 300) begin w++; tick(); end
    end
  endtask

  // Monitor: records events at the falling edge
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (medir_sensor === 1'b1) begin
        medir_cnt++;
        last_medir_cyc = cyc;
        if (pos_seen && (cyc - last_pos_cyc) < min_gap) min_gap = cyc - last_pos_cyc;
      end
      if (int'(posicao) != prev_pos) begin
        prev_pos     = int'(posicao);
        last_pos_cyc = cyc;
        pos_seen     = 1;
      end
      if (timeout === 1'b1) begin
        to_cnt++;
        last_to_cyc = cyc;
      end
      if (medida_valida === 1'b1)
        evq.push_back('{int'(posicao), int'(medida), int'(fim_varredura), medir_cnt, cyc});
    end
  end

  // Sensor model: answers 20 cycles after a request
  initial begin
    pronto_sensor = 1'b0;
    distancia     = 12'd0;
    forever begin
      @(negedge clock);
      if (medir_sensor === 1'b1 && resp_en) begin
        repeat (20) @(negedge clock);
        distancia     = 12'h123;
        pronto_sensor = 1'b1;
        @(negedge clock);
        pronto_sensor = 1'b0;
        distancia     = 12'd0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pp_pos[7], pp_fim[7], w, k, p, mc, e0, t0;
`ifdef CONTROLE_VARREDURA_PINGPONG_EN
    pp_pos = '{0, 1, 2, 3, 2, 1, 0};
    pp_fim = '{1, 0, 0, 1, 0, 0, 1};
    n_ev   = 7;
`else
    pp_pos = '{0, 1, 2, 3, 0, 0, 0};
    pp_fim = '{0, 0, 0, 1, 0, 0, 0};
    n_ev   = 5;
`endif
    for (int i = 0; i < 7; i++) tab[i] = '{pp_pos[i], 12'h123, pp_fim[i]};

    // Reset state
    reset = 1'b1; ligar = 1'b0;
    repeat (3) tick();
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_posicao", int'(posicao), 0);
    chk("rst_medida", int'(medida), 0);
    chk("rst_medir", int'(medir_sensor), 0);
    chk("rst_valida", int'(medida_valida), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_fim", int'(fim_varredura), 0);
    chk("rst_estado", int'(db_estado), 0);
    reset = 1'b0;
    tick();

    // Sweep with answering sensor; pwm widths at positions 0 and 1
    ligar = 1'b1;
    pulse(w);
    chk("pwm_width_pos0", w, 10);
    k = 0;
    while (posicao !== 2'd1 && k < 1000) begin tick(); k++; end
    chk("reach_pos1", int'(posicao), 1);
    pulse(w);
    pulse(w);
    chk("pwm_width_pos1", w, 15);
    k = 0;
    while (evq.size() < n_ev && k < 5000) begin tick(); k++; end
    resp_en = 0;
    chk("sweep_events", evq.size(), n_ev);
    for (int i = 0; i < n_ev && i < evq.size(); i++) begin
      chk($sformatf("ev%0d_posicao", i), evq[i].pos, tab[i].pos);
      chk($sformatf("ev%0d_medida", i), evq[i].med, tab[i].med);
      chk($sformatf("ev%0d_fim", i), evq[i].fim, tab[i].fim);
      chk($sformatf("ev%0d_medir_count", i), evq[i].nmed, i + 1);
    end
    chk("settle_ge_1_period", int'(min_gap >= PER), 1);

    // Sensor silent: timeout after 300 cycles, sweep continues
    mc = medir_cnt; t0 = to_cnt; e0 = evq.size();
    k = 0;
    while (medir_cnt == mc && k < 1000) begin tick(); k++; end
    chk("to_medir_seen", medir_cnt, mc + 1);
    chk("to_posicao", int'(posicao), 1);
    k = 0;
    while (evq.size() == e0 && k < 400) begin tick(); k++; end
    chk("to_event", evq.size(), e0 + 1);
    chk("to_pulse_count", to_cnt, t0 + 1);
    chk("to_latency", last_to_cyc - last_medir_cyc, 300);
    if (evq.size() > e0) begin
      chk("to_medida", evq[e0].med, 12'hFFF);
      chk("to_ev_posicao", evq[e0].pos, 1);
      chk("to_valid_after", evq[e0].cyc - last_to_cyc, 1);
    end
    k = 0;
    while (posicao === 2'd1 && k < 20) begin tick(); k++; end
    chk("to_next_pos", int'(posicao), 2);
    resp_en = 1;

    // ligar dropped in AGUARDA: measurement completes, then idle
    mc = medir_cnt; e0 = evq.size();
    k = 0;
    while (medir_cnt == mc && k < 1000) begin tick(); k++; end
    p = int'(posicao);
    chk("drop_posicao", p, 2);
    tick();
    chk("drop_in_aguarda", int'(db_estado), 3);
    ligar = 1'b0;
    k = 0;
    while (evq.size() == e0 && k < 100) begin tick(); k++; end
    chk("drop_event", evq.size(), e0 + 1);
    if (evq.size() > e0) chk("drop_medida", evq[e0].med, 12'h123);
    repeat (5) tick();
    chk("drop_estado", int'(db_estado), 0);
    chk("drop_next_pos", int'(posicao), 3);
    mc = medir_cnt;
    repeat (400) tick();
    chk("drop_no_medir", medir_cnt, mc);

    // Reset in AGUARDA, late pronto ignored
    ligar = 1'b1;
    mc = medir_cnt;
    k = 0;
    while (medir_cnt == mc && k < 1000) begin tick(); k++; end
    chk("rst2_posicao_before", int'(posicao), 3);
    reset = 1'b1; ligar = 1'b0;
    tick();
    chk("rst2_pwm", int'(pwm), 0);
    chk("rst2_posicao", int'(posicao), 0);
    chk("rst2_medida", int'(medida), 0);
    chk("rst2_estado", int'(db_estado), 0);
    chk("rst2_medir", int'(medir_sensor), 0);
    reset = 1'b0;
    e0 = evq.size();
    repeat (50) tick();
    chk("rst2_no_valid", evq.size(), e0);
    chk("rst2_medida_after", int'(medida), 0);
    chk("rst2_estado_after", int'(db_estado), 0);
    chk("rst2_posicao_after", int'(posicao), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
